// File: rtl/complex_operand_packer.sv
// complex_operand_packer: double-buffered stream-to-vector packer feeding the complex dot-product unit
module complex_operand_packer #(
  parameter int SIZE = 16,
  parameter int DATA_W = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [3:0][DATA_W-1:0]            elem_i,
  input  logic                              elem_valid_i,
  input  logic                              elem_last_i,
  output logic                              elem_ready_o,
  input  logic                              flush_i,
  output logic [SIZE*4-1:0][DATA_W-1:0]     operands_o,
  output logic [$clog2(SIZE+1)-1:0]         len_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              busy_o
);
  localparam int IW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE + 1);
  logic [SIZE-1:0][3:0][DATA_W-1:0] mem [2];
  logic [1:0]         full;
  logic [1:0][CW-1:0] cnt;
  logic [IW-1:0]      idx;
  logic               wr_bank, rd_bank, accept, close, fire;
  assign accept = elem_valid_i && !full[wr_bank];
  assign close = accept && (elem_last_i || idx == IW'(SIZE - 1));
  assign fire = full[rd_bank] && out_ready_i;
  assign elem_ready_o = !full[wr_bank];
  assign out_valid_o = full[rd_bank];
  assign len_o = cnt[rd_bank];
  assign busy_o = (|full) || (idx != '0);
  always_ff @(posedge clk_i)
    if (accept) mem[wr_bank][idx] <= elem_i;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      full <= '0;
      cnt <= '0;
      idx <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (accept) idx <= close ? '0 : idx + 1'b1;
      if (close) begin
        full[wr_bank] <= 1'b1;
        cnt[wr_bank] <= CW'(idx) + CW'(1);
        wr_bank <= ~wr_bank;
      end
      if (fire) begin
        full[rd_bank] <= 1'b0;
        cnt[rd_bank] <= '0;
        rd_bank <= ~rd_bank;
      end
    end
  end
  genvar k;
  for (k = 0; k < SIZE; k++) begin : g_lane
    assign operands_o[4*k +: 4] = (CW'(k) < cnt[rd_bank]) ? mem[rd_bank][k] : '0;
  end
endmodule

// File: tb/tb_complex_operand_packer.sv
// tb_complex_operand_packer: directed stimulus checked against a queue-based vector model every cycle
module tb_complex_operand_packer;
  localparam int SIZE = 16;
  localparam int DW = 64;
  typedef logic [SIZE*4-1:0][DW-1:0] vec_t;
  logic clk = 0, rst = 1, flush = 0;
  logic [3:0][DW-1:0] elem = '0;
  logic elem_valid = 0, elem_last = 0, out_ready = 0;
  logic elem_ready, out_valid, busy;
  vec_t operands;
  logic [4:0] len;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  vec_t qv[$];
  int ql[$];
  vec_t pv;
  int pn = 0;
  complex_operand_packer #(.SIZE(SIZE), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .elem_i(elem), .elem_valid_i(elem_valid),
    .elem_last_i(elem_last), .elem_ready_o(elem_ready), .flush_i(flush),
    .operands_o(operands), .len_o(len), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .busy_o(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bit fire, acc;
    if (rst || flush) begin
      qv.delete();
      ql.delete();
      pn = 0;
    end else begin
      fire = qv.size() > 0 && out_ready;
      acc = elem_valid && qv.size() < 2;
      if (fire) begin
        void'(qv.pop_front());
        void'(ql.pop_front());
      end
      if (acc) begin
        if (pn == 0) pv = '0;
        pv[4*pn +: 4] = elem;
        pn++;
        if (elem_last || pn == SIZE) begin
          qv.push_back(pv);
          ql.push_back(pn);
          pn = 0;
        end
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    vec_t ev;
    int bad;
    if (chk_en) begin
      ev = qv.size() > 0 ? qv[0] : '0;
      chk("model out_valid", 64'(out_valid), 64'(qv.size() > 0));
      chk("model elem_ready", 64'(elem_ready), 64'(qv.size() < 2));
      chk("model busy", 64'(busy), 64'(qv.size() > 0 || pn > 0));
      chk("model len", 64'(len), 64'(qv.size() > 0 ? ql[0] : 0));
      bad = -1;
      for (int w = SIZE*4-1; w >= 0; w--) if (operands[w] !== ev[w]) bad = w;
      if (bad < 0) chk("model operands", 64'(0), 64'(0) ^ 64'(operands[0] !== ev[0]));
      else chk($sformatf("model operands word %0d", bad), operands[bad], ev[bad]);
    end
  end
  task automatic stream(input int n, input int first, input int last_at);
    int t;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) elem[j] = 64'(4 * (first + i) + j);
      elem_valid = 1;
      elem_last = (i == last_at);
      t = 0;
      while (!elem_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("stream timeout", 64'(0), 64'(1));
      @(negedge clk);
    end
    elem_valid = 0;
    elem_last = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("reset out_valid", 64'(out_valid), 0);
    chk("reset elem_ready", 64'(elem_ready), 1);
    chk("reset busy", 64'(busy), 0);
    chk("reset len", 64'(len), 0);
    chk("reset operands", operands[17], 0);
    out_ready = 1;
    stream(16, 0, 15);
    chk("t1 valid", 64'(out_valid), 1);
    chk("t1 len", 64'(len), 16);
    chk("t1 word0", operands[0], 0);
    chk("t1 word37", operands[37], 37);
    chk("t1 word63", operands[63], 63);
    @(negedge clk);
    chk("t1 valid once", 64'(out_valid), 0);
    chk("t1 busy after", 64'(busy), 0);
    stream(5, 0, 4);
    chk("t2 len", 64'(len), 5);
    chk("t2 word19", operands[19], 19);
    chk("t2 pad20", operands[20], 0);
    chk("t2 pad63", operands[63], 0);
    @(negedge clk);
    chk("t2 busy after", 64'(busy), 0);
    out_ready = 0;
    stream(32, 200, -1);
    chk("t3 ready low", 64'(elem_ready), 0);
    chk("t3 len", 64'(len), 16);
    chk("t3 word0", operands[0], 800);
    repeat (10) @(negedge clk);
    chk("t3 held word5", operands[5], 805);
    fork
      stream(16, 232, -1);
      begin
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("t3 ready back", 64'(elem_ready), 1);
        chk("t3 vec1 word0", operands[0], 864);
      end
    join
    chk("t3 vec1 still", operands[1], 865);
    out_ready = 1;
    @(negedge clk);
    chk("t3 vec2 word0", operands[0], 928);
    @(negedge clk);
    chk("t3 drained", 64'(out_valid), 0);
    stream(20, 100, 19);
    chk("t4 B len", 64'(len), 4);
    chk("t4 B word0", operands[0], 464);
    chk("t4 B word15", operands[15], 479);
    chk("t4 B pad16", operands[16], 0);
    @(negedge clk);
    stream(7, 50, -1);
    for (int j = 0; j < 4; j++) elem[j] = 64'(9000 + j);
    elem_valid = 1;
    flush = 1;
    @(negedge clk);
    flush = 0;
    elem_valid = 0;
    chk("t5 busy", 64'(busy), 0);
    chk("t5 valid", 64'(out_valid), 0);
    stream(16, 300, 15);
    chk("t5 len", 64'(len), 16);
    chk("t5 word0", operands[0], 1200);
    chk("t5 word63", operands[63], 1263);
    @(negedge clk);
    out_ready = 0;
    stream(32, 400, -1);
    chk("t6 full", 64'(elem_ready), 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t6 valid", 64'(out_valid), 0);
    chk("t6 ready", 64'(elem_ready), 1);
    chk("t6 busy", 64'(busy), 0);
    chk("t6 word0", operands[0], 0);
    stream(3, 600, 2);
    chk("t6 len", 64'(len), 3);
    chk("t6 word0 new", operands[0], 2400);
    chk("t6 pad12", operands[12], 0);
    out_ready = 1;
    repeat (3) @(negedge clk);
    chk("end busy", 64'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
